// File: rtl/log_serial_arbiter.sv
// log_serial_arbiter: round-robin arbiter that shares one serial logging line
// between NUM_REQ sources. The winner's {id, data} frame is shifted out MSB
// first, followed by a GAP_CYCLES idle gap.
// Ports:
//   clk, reset_i         clock, asynchronous active-high reset
//   en_i                 arbitration enable (sampled in IDLE only)
//   req_i, data_i        per-source request level and log word
//   gnt_o                one-cycle one-hot grant, coincident with first bit
//   ser_en_o/do_o/sof_o  serial valid, data bit, start-of-frame
//   busy_o               high while shifting or in the gap
//   frm_cnt_o            completed-frame counter (wraps)
module log_serial_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      ser_en_o,
  output logic                      ser_do_o,
  output logic                      ser_sof_o,
  output logic                      busy_o,
  output logic [15:0]               frm_cnt_o
);

  localparam int unsigned ID_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FRAME_W  = ID_W + DATA_W;
  localparam int unsigned CNT_W    = $clog2(FRAME_W);
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_ptr;
  logic [FRAME_W-1:0]   r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_ser_en;
  logic                 r_ser_do;
  logic                 r_ser_sof;
  logic                 r_busy;
  logic [15:0]          r_frm_cnt;

  logic                 w_found;
  logic [ID_W-1:0]      w_win;
  logic [DATA_W-1:0]    w_word;
  logic [FRAME_W-1:0]   w_frame;
  logic [NUM_REQ-1:0]   w_gnt;
  int unsigned          w_dist;
  int unsigned          w_best;

  // Round-robin pick: smallest distance upward from pointer+1 wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_word  = '0;
    w_dist  = 0;
    w_best  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_dist = (k + 2 * NUM_REQ - 32'(r_ptr) - 1) % NUM_REQ;
      if (req_i[k] && (!w_found || (w_dist < w_best))) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_win   = ID_W'(k);
        w_word  = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_frame = {w_win, w_word};
  assign w_gnt   = NUM_REQ'(1) << w_win;

  // Control FSM with registered outputs. The shift register holds the bits
  // still to be sent, so the MSB on ser_do_o is already consumed from it.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= ID_W'(NUM_REQ - 1);
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_gnt     <= '0;
      r_ser_en  <= 1'b0;
      r_ser_do  <= 1'b0;
      r_ser_sof <= 1'b0;
      r_busy    <= 1'b0;
      r_frm_cnt <= '0;
    end else begin
      r_gnt     <= '0;
      r_ser_sof <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en_i && w_found) begin
            r_gnt     <= w_gnt;
            r_shift   <= w_frame << 1;
            r_ser_do  <= w_frame[FRAME_W-1];
            r_ser_en  <= 1'b1;
            r_ser_sof <= 1'b1;
            r_busy    <= 1'b1;
            r_ptr     <= w_win;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
            r_ser_en  <= 1'b0;
            r_ser_do  <= 1'b0;
            r_frm_cnt <= r_frm_cnt + 16'd1;
            r_gap_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_ser_do  <= r_shift[FRAME_W-1];
            r_shift   <= r_shift << 1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign ser_en_o  = r_ser_en;
  assign ser_do_o  = r_ser_do;
  assign ser_sof_o = r_ser_sof;
  assign busy_o    = r_busy;
  assign frm_cnt_o = r_frm_cnt;

endmodule

// File: tb/tb_log_serial_arbiter.sv
// Directed bench for log_serial_arbiter: a default instance (4 sources,
// 16-bit words, 2 gap cycles) and a minimal instance (2 sources, 1-bit
// words, no gap).
module tb_log_serial_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  gnt;
  logic        ser_en, ser_do, sof, busy;
  logic [15:0] frm_cnt;

  logic [1:0]  req2;
  logic [1:0]  data2;
  logic [1:0]  gnt2;
  logic        ser_en2, ser_do2, sof2, busy2;
  logic [15:0] frm_cnt2;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  log_serial_arbiter #(.NUM_REQ(4), .DATA_W(16), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .reset_i(reset_i), .en_i(en_i), .req_i(req), .data_i(data),
    .gnt_o(gnt), .ser_en_o(ser_en), .ser_do_o(ser_do), .ser_sof_o(sof),
    .busy_o(busy), .frm_cnt_o(frm_cnt)
  );

  log_serial_arbiter #(.NUM_REQ(2), .DATA_W(1), .GAP_CYCLES(0)) u_dut2 (
    .clk(clk), .reset_i(reset_i), .en_i(en_i), .req_i(req2), .data_i(data2),
    .gnt_o(gnt2), .ser_en_o(ser_en2), .ser_do_o(ser_do2), .ser_sof_o(sof2),
    .busy_o(busy2), .frm_cnt_o(frm_cnt2)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [17:0] frame;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_sof(output int c);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!sof && n < 40);
    check("sof_seen", 32'(sof), 32'd1);
    c = cyc;
  endtask

  // Capture one frame from the default instance and check it, then step
  // into the first gap cycle and check the frame counter.
  task automatic get_frame(input string nm, input logic [3:0] eg, input logic [17:0] ef,
                           output int sc, output int lc);
    logic [17:0] f;
    f = '0;
    wait_sof(sc);
    check({nm, "_gnt"}, 32'(gnt), 32'(eg));
    for (int b = 0; b < 18; b++) begin
      if (b > 0) begin
        tick();
        check({nm, "_sof_gnt_low"}, 32'({sof, gnt}), 32'd0);
      end
      check({nm, "_en_busy"}, 32'({ser_en, busy}), 32'd3);
      f = {f[16:0], ser_do};
    end
    lc = cyc;
    check({nm, "_frame"}, 32'(f), 32'(ef));
    tick();
    exp_cnt++;
    check({nm, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_cnt));
    check({nm, "_gap_en"}, 32'(ser_en), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc, lc, prev_lc;
    logic [15:0] words [4];
    logic [1:0]  f2;
    logic        b0;
    int          n;

    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'hA5C3; words[3] = 16'h0F0F;
    data  = {words[3], words[2], words[1], words[0]};
    data2 = 2'b10;

    // Pointer starts at 3; expected winners hand-derived in sequence.
    vecs[0] = '{req: 4'b0100, gnt: 4'b0100, frame: 18'h2A5C3};
    vecs[1] = '{req: 4'b0011, gnt: 4'b0001, frame: 18'h01234};
    vecs[2] = '{req: 4'b1010, gnt: 4'b0010, frame: 18'h1BEEF};
    vecs[3] = '{req: 4'b1010, gnt: 4'b1000, frame: 18'h30F0F};
    vecs[4] = '{req: 4'b1111, gnt: 4'b0001, frame: 18'h01234};
    vecs[5] = '{req: 4'b0001, gnt: 4'b0001, frame: 18'h01234};

    reset_i = 1'b1; en_i = 1'b1; req = '0; req2 = '0;
    #1;
    check("rst_outputs", 32'({gnt, ser_en, ser_do, sof, busy}), 32'd0);
    check("rst_frm_cnt", 32'(frm_cnt), 32'd0);
    tick(); tick();
    reset_i = 1'b0;

    // Table: one request pattern per entry, full frame plus gap.
    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req;
      get_frame($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].frame, sc, lc);
      req = '0;
      tick();
      check($sformatf("vec%0d_gap2", i), 32'({busy, ser_en}), 32'b10);
      tick();
      check($sformatf("vec%0d_idle", i), 32'({busy, ser_en}), 32'b00);
    end

    // All sources held: rotation 0,1,2,3,0 with 3 idle cycles between frames.
    reset_i = 1'b1; tick(); reset_i = 1'b0; exp_cnt = 0;
    req = 4'b1111;
    prev_lc = 0;
    for (int k = 0; k < 5; k++) begin
      get_frame($sformatf("rr%0d", k), 4'(1 << (k % 4)), {2'(k % 4), words[k % 4]}, sc, lc);
      if (k > 0) check($sformatf("rr%0d_spacing", k), 32'(sc - prev_lc - 1), 32'd3);
      prev_lc = lc;
    end

    // Single source held: back-to-back grants to source 1.
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      get_frame($sformatf("solo%0d", k), 4'b0010, 18'h1BEEF, sc, lc);
      if (k > 0) check($sformatf("solo%0d_spacing", k), 32'(sc - prev_lc - 1), 32'd3);
      prev_lc = lc;
    end

    // en_i dropped at bit 5: frame completes, no grant until re-enabled.
    wait_sof(sc);
    check("en_gnt", 32'(gnt), 32'b0010);
    for (int b = 1; b < 18; b++) begin
      tick();
      check("en_mid_frame", 32'(ser_en), 32'd1);
      if (b == 5) begin
        en_i = 1'b0;
        req  = 4'b0011;
      end
    end
    tick();
    exp_cnt++;
    check("en_frm_cnt", 32'(frm_cnt), 32'(exp_cnt));
    for (int i = 0; i < 12; i++) begin
      tick();
      check("en_low_no_gnt", 32'({gnt, ser_en}), 32'd0);
    end
    check("en_low_idle", 32'(busy), 32'd0);
    en_i = 1'b1;
    get_frame("en_resume", 4'b0001, 18'h01234, sc, lc);
    req = '0;

    // Reset in the middle of a source-2 frame.
    req = 4'b0100;
    wait_sof(sc);
    check("rst_gnt", 32'(gnt), 32'b0100);
    req = '0;
    for (int b = 1; b <= 7; b++) tick();
    check("rst_bit7", 32'({ser_en, ser_do}), 32'b11);
    reset_i = 1'b1;
    #1;
    check("rst_async", 32'({ser_en, ser_do, busy}), 32'd0);
    check("rst_async_cnt", 32'(frm_cnt), 32'd0);
    tick();
    req = 4'b1010;
    reset_i = 1'b0;
    exp_cnt = 0;
    get_frame("rst_first", 4'b0010, 18'h1BEEF, sc, lc);
    req = 4'b1000;
    get_frame("rst_second", 4'b1000, 18'h30F0F, sc, lc);
    req = '0;

    // Minimal instance: 2-bit frames, one idle cycle, alternating ids.
    req2 = 2'b11;
    prev_lc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!sof2 && n < 10);
      check("m_sof_seen", 32'(sof2), 32'd1);
      sc = cyc;
      check($sformatf("m%0d_gnt", k), 32'(gnt2), (k % 2 == 0) ? 32'b01 : 32'b10);
      b0 = ser_do2;
      tick();
      check($sformatf("m%0d_bit1", k), 32'({ser_en2, sof2, gnt2}), 32'b1000);
      f2 = {b0, ser_do2};
      check($sformatf("m%0d_frame", k), 32'(f2), (k % 2 == 0) ? 32'b00 : 32'b11);
      if (k > 0) check($sformatf("m%0d_spacing", k), 32'(sc - prev_lc - 1), 32'd1);
      prev_lc = cyc;
      tick();
      check($sformatf("m%0d_cnt", k), 32'({ser_en2, frm_cnt2}), 32'(k + 1));
    end
    req2 = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
